word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/serializer_pkg.sv | 19 +
 rtl/lane_select.sv | 25 ++
 rtl/word_serializer.sv | 149 ++++++++++++++
 tb/tb_word_serializer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared definitions for the word serializer: FSM state encoding and the
// ceiling-log2 helper that sizes the lane index.
package serializer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/lane_select.sv
// Combinational mux returning lane idx_i of word_i; lane 0 is the least
// significant LANE_W bits.
import serializer_pkg::*;

module lane_select #(
    parameter  int WORD_W = 32,
    parameter  int LANE_W = 8,
    localparam int LANES  = WORD_W / LANE_W,
    localparam int IDX_W  = clog2(LANES)
) (
    input  logic [WORD_W-1:0] word_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [LANE_W-1:0] lane_o
);

    always_comb begin
        lane_o = '0;
        for (int j = 0; j < LANES; j++) begin
            if (idx_i == IDX_W'(j)) begin
                lane_o = word_i[j*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/word_serializer.sv
// Splits WORD_W-bit words into LANE_W-bit lanes, LSB- or MSB-first, with a
// zero-bubble handoff between words. Define SERIALIZER_SKIP_ZERO_EN to drop zero lanes.
import serializer_pkg::*;

module word_serializer #(
    parameter  int WORD_W = 32,
    parameter  int LANE_W = 8,
    localparam int LANES  = WORD_W / LANE_W,
    localparam int IDX_W  = clog2(LANES)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_msb_first,
    output logic              in_ready,
    output logic              out_valid,
    output logic [LANE_W-1:0] out_lane,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    input  logic              out_ready
);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                msb_q, msb_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic [LANES-1:0]    cand_in, cand_held;
    logic [IDX_W:0]      first_res, next_res;
    logic [IDX_W-1:0]    first_idx;
    int                  first_start, next_from;
    logic                load, fire;

    // Nearest candidate lane at or beyond 'from' in the travel direction;
    // MSB bit of the result flags whether one exists.
    function automatic logic [IDX_W:0] find_lane(input logic [LANES-1:0] cand,
                                                 input int from,
                                                 input logic msb);
        logic             found;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        if (msb) begin
            for (int j = 0; j < LANES; j++) begin
                if (cand[j] && j <= from) begin
                    found = 1'b1;
                    idx   = IDX_W'(j);
                end
            end
        end else begin
            for (int j = LANES - 1; j >= 0; j--) begin
                if (cand[j] && j >= from) begin
                    found = 1'b1;
                    idx   = IDX_W'(j);
                end
            end
        end
        return {found, idx};
    endfunction

`ifdef SERIALIZER_SKIP_ZERO_EN
    function automatic logic [LANES-1:0] lane_nonzero(input logic [WORD_W-1:0] w);
        logic [LANES-1:0] nz;
        for (int j = 0; j < LANES; j++) begin
            nz[j] = |w[j*LANE_W +: LANE_W];
        end
        return nz;
    endfunction

    assign cand_in   = lane_nonzero(in_word);
    assign cand_held = lane_nonzero(word_q);
`else
    assign cand_in   = '1;
    assign cand_held = '1;
`endif

    // An all-zero word (skip mode) still emits its first-order lane.
    assign first_start = in_msb_first ? LANES - 1 : 0;
    assign first_res   = find_lane(cand_in, first_start, in_msb_first);
    assign first_idx   = first_res[IDX_W] ? first_res[IDX_W-1:0] : IDX_W'(first_start);

    assign next_from = msb_q ? int'(idx_q) - 1 : int'(idx_q) + 1;
    assign next_res  = find_lane(cand_held, next_from, msb_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            msb_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            msb_q   <= msb_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        msb_d     = msb_q;
        idx_d     = idx_q;
        out_valid = 1'b0;
        out_last  = 1'b0;
        in_ready  = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = reset_n;
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = ~next_res[IDX_W];
                in_ready  = reset_n & out_last & out_ready;
            end
            default: ;
        endcase

        load = in_valid & in_ready;
        fire = out_valid & out_ready;

        if (load) begin
            state_d = SEND;
            word_d  = in_word;
            msb_d   = in_msb_first;
            idx_d   = first_idx;
        end else if (fire) begin
            if (out_last) begin
                state_d = IDLE;
            end else begin
                idx_d = next_res[IDX_W-1:0];
            end
        end
    end

    assign out_idx = idx_q;

    lane_select #(
        .WORD_W (WORD_W),
        .LANE_W (LANE_W)
    ) u_lane_select (
        .word_i (word_q),
        .idx_i  (idx_q),
        .lane_o (out_lane)
    );

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer (32-bit word, 8-bit lanes).
module tb_word_serializer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_word = '0;
    logic        in_msb_first = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_lane;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    word_serializer #(.WORD_W(32), .LANE_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_word      (in_word),
        .in_msb_first (in_msb_first),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_lane     (out_lane),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++;
        if ({in_ready, out_valid, out_last, out_idx, out_lane} !== 13'h0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b last=%b idx=%0d lane=%h, expected all 0",
                     in_ready, out_valid, out_last, out_idx, out_lane);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b vld=%b, expected rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    // Per-cycle observation vector: {out_valid, out_idx, out_last, in_ready, out_lane}
    task automatic test_lsb_first();
        logic [7:0]  lanes [4];
        logic [12:0] want;
        lanes = '{8'h10, 8'h00, 8'hff, 8'hff};
        in_valid = 1'b1; in_word = 32'hffff0010; in_msb_first = 1'b0; out_ready = 1'b1;
        step();
        in_valid = 1'b0; in_word = 32'h0; in_msb_first = 1'b1;
        for (int i = 0; i < 4; i++) begin
            want = {1'b1, 2'(i), (i == 3), (i == 3), lanes[i]};
            checks++;
            if ({out_valid, out_idx, out_last, in_ready, out_lane} !== want) begin
                errors++;
                $display("FAIL lsb_first[%0d]: got vld=%b idx=%0d last=%b rdy=%b lane=%h, expected %h",
                         i, out_valid, out_idx, out_last, in_ready, out_lane, want);
            end
            step();
        end
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL lsb_idle: got vld=%b rdy=%b, expected vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0]  lanes [4];
        logic [12:0] want;
        lanes = '{8'h0f, 8'hf0, 8'hf0, 8'h0f};
        in_valid = 1'b1; in_word = 32'h0ff0f00f; in_msb_first = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; in_msb_first = 1'b0;
        for (int i = 0; i < 4; i++) begin
            want = {1'b1, 2'(3 - i), (i == 3), (i == 3), lanes[i]};
            checks++;
            if ({out_valid, out_idx, out_last, in_ready, out_lane} !== want) begin
                errors++;
                $display("FAIL msb_first[%0d]: got vld=%b idx=%0d last=%b rdy=%b lane=%h, expected %h",
                         i, out_valid, out_idx, out_last, in_ready, out_lane, want);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL msb_idle: got vld=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  lanes [8];
        logic [1:0]  idxs [8];
        logic [12:0] want;
        lanes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h88, 8'h77, 8'h66, 8'h55};
        idxs  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        in_valid = 1'b1; in_word = 32'h44332211; in_msb_first = 1'b0; out_ready = 1'b1;
        step();
        in_word = 32'h88776655; in_msb_first = 1'b1;
        for (int c = 0; c < 8; c++) begin
            want = {1'b1, idxs[c], (c == 3 || c == 7), (c == 3 || c == 7), lanes[c]};
            checks++;
            if ({out_valid, out_idx, out_last, in_ready, out_lane} !== want) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got vld=%b idx=%0d last=%b rdy=%b lane=%h, expected %h",
                         c, out_valid, out_idx, out_last, in_ready, out_lane, want);
            end
            if (c == 4) begin
                in_valid = 1'b0; in_word = 32'hdeadbeef; in_msb_first = 1'b0;
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_idle: got vld=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_stall();
        logic [12:0] want;
        in_valid = 1'b1; in_word = 32'h44332211; in_msb_first = 1'b0; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        // Offer a competing word while stalled; it must not be taken.
        in_valid = 1'b1; in_word = 32'haaaaaaaa; out_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            want = {1'b1, 2'd1, 1'b0, 1'b0, 8'h22};
            checks++;
            if ({out_valid, out_idx, out_last, in_ready, out_lane} !== want) begin
                errors++;
                $display("FAIL stall[%0d]: got vld=%b idx=%0d last=%b rdy=%b lane=%h, expected %h",
                         s, out_valid, out_idx, out_last, in_ready, out_lane, want);
            end
            if (s < 3) step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        want = {1'b1, 2'd2, 1'b0, 1'b0, 8'h33};
        checks++;
        if ({out_valid, out_idx, out_last, in_ready, out_lane} !== want) begin
            errors++;
            $display("FAIL stall_resume: got vld=%b idx=%0d last=%b rdy=%b lane=%h, expected %h",
                     out_valid, out_idx, out_last, in_ready, out_lane, want);
        end
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle: got vld=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_word();
        in_valid = 1'b1; in_word = 32'h12345678; in_msb_first = 1'b0; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        checks++;
        if ({out_valid, out_idx, out_lane} !== {1'b1, 2'd2, 8'h34}) begin
            errors++;
            $display("FAIL rst_mid_pending: got vld=%b idx=%0d lane=%h, expected vld=1 idx=2 lane=34",
                     out_valid, out_idx, out_lane);
        end
        out_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_last, out_idx, out_lane} !== 13'h0) begin
            errors++;
            $display("FAIL rst_mid_async: got rdy=%b vld=%b last=%b idx=%0d lane=%h, expected all 0",
                     in_ready, out_valid, out_last, out_idx, out_lane);
        end
        @(negedge clk);
        reset_n = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL rst_mid_release: got rdy=%b vld=%b, expected rdy=1 vld=0", in_ready, out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_no_lanes[%0d]: got vld=%b, expected 0", k, out_valid);
            end
        end
    endtask

    task automatic test_zero_lanes();
        logic [12:0] want;
`ifdef SERIALIZER_SKIP_ZERO_EN
        logic [12:0] exp_seq [3];
        exp_seq = '{{1'b1, 2'd2, 1'b0, 1'b0, 8'hff},
                    {1'b1, 2'd3, 1'b1, 1'b1, 8'hff},
                    {1'b1, 2'd0, 1'b1, 1'b1, 8'h00}};
        in_valid = 1'b1; in_word = 32'hffff0000; in_msb_first = 1'b0; out_ready = 1'b1;
        step();
        in_word = 32'h0;
        for (int c = 0; c < 3; c++) begin
            want = exp_seq[c];
            checks++;
            if ({out_valid, out_idx, out_last, in_ready, out_lane} !== want) begin
                errors++;
                $display("FAIL skip_zero[%0d]: got vld=%b idx=%0d last=%b rdy=%b lane=%h, expected %h",
                         c, out_valid, out_idx, out_last, in_ready, out_lane, want);
            end
            if (c == 1) in_valid = 1'b1;
            if (c == 2) in_valid = 1'b0;
            step();
        end
`else
        logic [7:0] lanes [4];
        lanes = '{8'h00, 8'h00, 8'hff, 8'hff};
        in_valid = 1'b1; in_word = 32'hffff0000; in_msb_first = 1'b0; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            want = {1'b1, 2'(c), (c == 3), (c == 3), lanes[c]};
            checks++;
            if ({out_valid, out_idx, out_last, in_ready, out_lane} !== want) begin
                errors++;
                $display("FAIL zero_lanes[%0d]: got vld=%b idx=%0d last=%b rdy=%b lane=%h, expected %h",
                         c, out_valid, out_idx, out_last, in_ready, out_lane, want);
            end
            step();
        end
`endif
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_lanes_idle: got vld=%b, expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_back_to_back();
        test_stall();
        test_reset_mid_word();
        test_zero_lanes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
